// File: rtl/fp_unit_arbiter_pkg.sv
// fp_arb_pkg: shared types and constants for the FP unit arbiter.
// Holds the arbiter state encoding, FP opcode/result constants and default widths.
package fp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_t;

  localparam logic [7:0]  FP_OP_SQRT = 8'd3;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_FP_WIDTH       = 32;
  localparam int DEF_OP_WIDTH       = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/fp_unit_arbiter_if.sv
// fp_unit_arbiter_if: requester bus and FP unit custom-instruction bus.
// Handshake: a requester holds req_valid with its op/operands until it sees its
// req_ready bit high in the same cycle (acceptance at that clock edge); it may drop
// req_valid earlier to withdraw. The result arrives later as a one-cycle rsp_valid
// pulse with rsp_data; there is no backpressure on the response.
// master = requesters + FP unit side, slave = the arbiter.
interface fp_unit_arbiter_if
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int fp_width = DEF_FP_WIDTH,
  parameter int op_width = DEF_OP_WIDTH
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*op_width-1:0] req_op;
  logic [NUM_REQ*fp_width-1:0] req_dataa;
  logic [NUM_REQ*fp_width-1:0] req_datab;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [fp_width-1:0]         rsp_data;
  logic                        fpu_start;
  logic                        fpu_clk_en;
  logic                        fpu_reset;
  logic [op_width-1:0]         fpu_n;
  logic [fp_width-1:0]         fpu_dataa;
  logic [fp_width-1:0]         fpu_datab;
  logic                        fpu_done;
  logic [fp_width-1:0]         fpu_result;

  modport master (
    output req_valid, req_op, req_dataa, req_datab, fpu_done, fpu_result,
    input  req_ready, rsp_valid, rsp_data, fpu_start, fpu_clk_en, fpu_reset,
           fpu_n, fpu_dataa, fpu_datab
  );

  modport slave (
    input  req_valid, req_op, req_dataa, req_datab, fpu_done, fpu_result,
    output req_ready, rsp_valid, rsp_data, fpu_start, fpu_clk_en, fpu_reset,
           fpu_n, fpu_dataa, fpu_datab
  );
endinterface

// File: rtl/fp_unit_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker.
// Returns the first valid index searching upward from (last_grant+1) mod NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      grant,
  output logic               any_valid
);

  // Scan the rotated order once; the first hit wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!any_valid && valid[idx]) begin
        any_valid = 1'b1;
        grant     = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: shares one multicycle FP custom-instruction unit among NUM_REQ
// requesters, one operation in flight. IDLE -> ISSUE -> WAIT -> RESPOND.
// Optional feature macro: FP_ARB_TIMEOUT_EN (WAIT watchdog, returns quiet NaN).
module fp_unit_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int fp_width       = DEF_FP_WIDTH,
  parameter int op_width       = DEF_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  fp_unit_arbiter_if.slave   bus,
  output logic               busy,
  output logic               timeout_err,
  output arb_state_t         state_dbg
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fp_unit_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("fp_unit_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t          state, state_n;
  logic [GW-1:0]       grant, grant_q, last_grant;
  logic                any_valid;
  logic                wait_timeout;
  logic [op_width-1:0] n_q;
  logic [fp_width-1:0] a_q, b_q, result_q;

  rr_picker #(.NUM_REQ(NUM_REQ), .GW(GW)) u_picker (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state: fpu_done only matters while waiting.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (any_valid) state_n = ST_ISSUE;
      ST_ISSUE:   state_n = ST_WAIT;
      ST_WAIT:    if (bus.fpu_done || wait_timeout) state_n = ST_RESPOND;
      ST_RESPOND: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; request/response strobes are one-hot on the grant.
  always_comb begin
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    bus.rsp_data   = '0;
    bus.fpu_start  = 1'b0;
    bus.fpu_clk_en = 1'b0;
    case (state)
      ST_IDLE:    if (any_valid) bus.req_ready[grant] = 1'b1;
      ST_ISSUE:   begin bus.fpu_start = 1'b1; bus.fpu_clk_en = 1'b1; end
      ST_WAIT:    bus.fpu_clk_en = 1'b1;
      ST_RESPOND: begin bus.rsp_valid[grant_q] = 1'b1; bus.rsp_data = result_q; end
      default:    ;
    endcase
  end

  // Datapath: capture the winner's operands on accept, the result on done/timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      n_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_valid) begin
          grant_q <= grant;
          n_q     <= bus.req_op[int'(grant)*op_width +: op_width];
          a_q     <= bus.req_dataa[int'(grant)*fp_width +: fp_width];
          b_q     <= bus.req_datab[int'(grant)*fp_width +: fp_width];
        end
        ST_WAIT: begin
          if (bus.fpu_done)      result_q <= bus.fpu_result;
          else if (wait_timeout) result_q <= fp_width'(FP_QNAN);
        end
        ST_RESPOND: last_grant <= grant_q;
        default: ;
      endcase
    end
  end

  assign bus.fpu_n     = n_q;
  assign bus.fpu_dataa = a_q;
  assign bus.fpu_datab = b_q;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

`ifdef FP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          timed_out_q;
  logic          timeout_err_q;

  // Watchdog: counter cleared entering WAIT, flags sticky error and a unit reset pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt        <= '0;
      timed_out_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state == ST_ISSUE)     to_cnt <= '0;
      else if (state == ST_WAIT) to_cnt <= to_cnt + 1'b1;
      if (wait_timeout) begin
        timed_out_q   <= 1'b1;
        timeout_err_q <= 1'b1;
      end else if (state == ST_RESPOND) begin
        timed_out_q <= 1'b0;
      end
    end
  end

  assign wait_timeout  = (state == ST_WAIT) && !bus.fpu_done &&
                         (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err   = timeout_err_q;
  assign bus.fpu_reset = rst | ((state == ST_RESPOND) && timed_out_q);
`else
  assign wait_timeout  = 1'b0;
  assign timeout_err   = 1'b0;
  assign bus.fpu_reset = rst;
`endif

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter: directed test of the FP unit arbiter with a behavioural FPU.
// Optional feature macro: FP_ARB_TIMEOUT_EN (enables the watchdog step).
module tb_fp_unit_arbiter;
  import fp_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic       timeout_err;
  arb_state_t state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  fp_unit_arbiter_if #(.NUM_REQ(4), .fp_width(32), .op_width(8)) bus ();

  fp_unit_arbiter #(.NUM_REQ(4), .fp_width(32), .op_width(8), .TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural FPU: done pulses lat cycles after the start cycle.
  int          lat        = 5;
  logic        never_done = 1'b0;
  logic        m_active   = 1'b0;
  int          m_cnt      = 0;
  logic [31:0] m_res      = '0;

  always @(posedge clk) begin
    if (bus.fpu_reset) begin
      m_active <= 1'b0;
    end else if (bus.fpu_start) begin
      m_active <= 1'b1;
      m_cnt    <= lat - 1;
      m_res    <= (bus.fpu_n == FP_OP_SQRT && bus.fpu_dataa == 32'h4080_0000) ?
                  32'h4000_0000 : (bus.fpu_dataa ^ bus.fpu_datab);
    end else if (m_active) begin
      if (m_cnt == 0) m_active <= 1'b0;
      else            m_cnt    <= m_cnt - 1;
    end
  end

  assign bus.fpu_done   = m_active && (m_cnt == 0) && !never_done;
  assign bus.fpu_result = m_res;

  // Stimulus tables: op 1 on the model is dataa ^ datab.
  logic [31:0] tab_a   [4] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
  logic [31:0] tab_b   [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400};
  logic [31:0] tab_res [4] = '{32'h0000_0111, 32'h0000_0222, 32'h0000_0333, 32'h0000_0444};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_op[i*8 +: 8]     = op;
    bus.req_dataa[i*32 +: 32] = a;
    bus.req_datab[i*32 +: 32] = b;
  endtask

  task automatic wait_ready();
    #1;
    for (int n = 0; n < 50 && bus.req_ready == '0; n++) tick();
  endtask

  task automatic wait_rsp();
    #1;
    for (int n = 0; n < 200 && bus.rsp_valid == '0; n++) tick();
  endtask

  initial begin
    int r0;
    int other;
    int rdy;
    int early;
    logic [31:0] r0_data;
    logic [3:0]  exp_g;

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_dataa = '0;
    bus.req_datab = '0;

    // Reset and reset values
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_start", 32'(bus.fpu_start), 32'd0);
    chk("rst_clk_en", 32'(bus.fpu_clk_en), 32'd0);
    chk("rst_fpu_reset", 32'(bus.fpu_reset), 32'd0);
    chk("rst_fpu_n", 32'(bus.fpu_n), 32'd0);
    chk("rst_fpu_dataa", bus.fpu_dataa, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Single sqrt request, latency 5
    lat = 5;
    set_req(0, FP_OP_SQRT, 32'h4080_0000, 32'h0);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_ready_T", 32'(bus.req_ready), 32'h1);
    tick();
    chk("t1_start_T1", 32'(bus.fpu_start), 32'd1);
    chk("t1_state_T1", 32'(state_dbg), 32'(ST_ISSUE));
    chk("t1_fpu_n", 32'(bus.fpu_n), 32'd3);
    chk("t1_fpu_dataa", bus.fpu_dataa, 32'h4080_0000);
    chk("t1_busy", 32'(busy), 32'd1);
    bus.req_valid = '0;
    set_req(0, 8'hFF, 32'hDEAD_BEEF, 32'h1234_5678);
    tick();
    chk("t1_start_T2", 32'(bus.fpu_start), 32'd0);
    chk("t1_clk_en_T2", 32'(bus.fpu_clk_en), 32'd1);
    chk("t1_state_T2", 32'(state_dbg), 32'(ST_WAIT));
    chk("t1_hold_dataa", bus.fpu_dataa, 32'h4080_0000);
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk("t1_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    chk("t1_rsp_valid_T7", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_data_T7", bus.rsp_data, 32'h4000_0000);
    tick();
    chk("t1_back_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("t1_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    chk("t1_data_cleared", bus.rsp_data, 32'd0);

    // All four valid from reset: grants 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    lat = 2;
    for (int i = 0; i < 4; i++) set_req(i, 8'h01, tab_a[i], tab_b[i]);
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_g = 4'(j % 4);
      wait_ready();
      chk("t2_grant", 32'(bus.req_ready), 32'(4'b0001 << exp_g));
      wait_rsp();
      chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'(4'b0001 << exp_g));
      chk("t2_rsp_data", bus.rsp_data, tab_res[exp_g[1:0]]);
      if (j == 4) bus.req_valid = '0;
      tick();
    end

    // Requester 2 last; then 1 and 3 valid -> 3 before 1
    bus.req_valid = 4'b0100;
    wait_ready();
    chk("t3_grant2", 32'(bus.req_ready), 32'h4);
    wait_rsp();
    chk("t3_rsp2", 32'(bus.rsp_valid), 32'h4);
    chk("t3_rsp2_data", bus.rsp_data, 32'h0000_0333);
    bus.req_valid = 4'b1010;
    tick();
    #1;
    chk("t3_grant3_first", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0010;
    wait_rsp();
    chk("t3_rsp3", 32'(bus.rsp_valid), 32'h8);
    chk("t3_rsp3_data", bus.rsp_data, 32'h0000_0444);
    tick();
    wait_ready();
    chk("t3_grant1", 32'(bus.req_ready), 32'h2);
    wait_rsp();
    chk("t3_rsp1", 32'(bus.rsp_valid), 32'h2);
    chk("t3_rsp1_data", bus.rsp_data, 32'h0000_0222);
    bus.req_valid = '0;
    tick();

    // Requester 1 withdraws while requester 0 is in WAIT
    lat = 3;
    bus.req_valid = 4'b0011;
    #1;
    chk("t4_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    tick();
    chk("t4_in_wait", 32'(state_dbg), 32'(ST_WAIT));
    bus.req_valid = 4'b0000;
    r0 = 0; other = 0; rdy = 0; r0_data = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.rsp_valid[0]) begin r0++; r0_data = bus.rsp_data; end
      if ((bus.rsp_valid & 4'b1110) != 0) other++;
      if (bus.req_ready != 0) rdy++;
    end
    chk("t4_rsp0_count", 32'(r0), 32'd1);
    chk("t4_rsp0_data", r0_data, 32'h0000_0111);
    chk("t4_no_spurious_rsp", 32'(other), 32'd0);
    chk("t4_no_grant", 32'(rdy), 32'd0);

    // Reset during WAIT
    lat = 5;
    bus.req_valid = 4'b0100;
    #1;
    chk("t5_grant2", 32'(bus.req_ready), 32'h4);
    tick();
    tick();
    chk("t5_in_wait", 32'(state_dbg), 32'(ST_WAIT));
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    chk("t5_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_clk_en", 32'(bus.fpu_clk_en), 32'd0);
    chk("t5_fpu_n", 32'(bus.fpu_n), 32'd0);
    chk("t5_fpu_dataa", bus.fpu_dataa, 32'd0);
    chk("t5_fpu_reset", 32'(bus.fpu_reset), 32'd1);
    rst = 1'b0;
    other = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.rsp_valid != 0) other++;
    end
    chk("t5_no_rsp_after_abort", 32'(other), 32'd0);
    bus.req_valid = 4'b0101;
    #1;
    chk("t5_priority0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    wait_rsp();
    chk("t5_rsp0", 32'(bus.rsp_valid), 32'h1);
    chk("t5_rsp0_data", bus.rsp_data, 32'h0000_0111);
    tick();

`ifdef FP_ARB_TIMEOUT_EN
    // Watchdog: FPU never completes
    never_done = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    chk("t6_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    tick();
    chk("t6_in_wait", 32'(state_dbg), 32'(ST_WAIT));
    early = 0;
    for (int k = 1; k <= 63; k++) begin
      tick();
      if (bus.rsp_valid != 0) early++;
    end
    chk("t6_no_early_rsp", 32'(early), 32'd0);
    tick();
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t6_rsp_qnan", bus.rsp_data, FP_QNAN);
    chk("t6_fpu_reset_pulse", 32'(bus.fpu_reset), 32'd1);
    chk("t6_timeout_err", 32'(timeout_err), 32'd1);
    tick();
    chk("t6_fpu_reset_low", 32'(bus.fpu_reset), 32'd0);
    chk("t6_timeout_sticky", 32'(timeout_err), 32'd1);
    chk("t6_idle", 32'(state_dbg), 32'(ST_IDLE));
    never_done = 1'b0;
`else
    early = 0;
    chk("end_timeout_err_tied", 32'(timeout_err), 32'(early));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
